// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator: frames signed 8-bit Booth products into a wide signed sum behind valid/ready handshakes (optional clamp-on-overflow via BOOTH_ACC_SAT_EN)
module booth_product_accumulator #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  typedef enum logic {ACCUM, DONE} state_t;
  state_t state, state_nxt;
  logic [ACC_W-1:0] acc, addend, sum, acc_nxt;
  logic [CNT_W-1:0] count;
  logic ovf, take, sum_ovf;
  assign in_ready  = state == ACCUM;
  assign out_valid = state == DONE;
  assign out_acc   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;
  assign take      = in_valid && in_ready;
  // sign-extended add with overflow detect; clamp toward the addend's sign when saturation is built in
  always_comb begin
    addend  = ACC_W'($signed(in_prod));
    sum     = acc + addend;
    sum_ovf = (acc[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
`ifdef BOOTH_ACC_SAT_EN
    acc_nxt = !sum_ovf ? sum : addend[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
    acc_nxt = sum;
`endif
  end
  // frame ends on an accepted last-marker; result leaves when downstream takes it
  always_comb begin
    state_nxt = state;
    if (state == ACCUM && take && in_last) state_nxt = DONE;
    else if (state == DONE && out_ready) state_nxt = ACCUM;
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else state <= state_nxt;
  end
  // running sum, saturating product count and sticky overflow; cleared on reset or result handoff
  always_ff @(posedge clk) begin
    if (!rst_n || (state == DONE && out_ready)) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (take) begin
      acc   <= acc_nxt;
      count <= &count ? count : count + 1'b1;
      ovf   <= ovf | sum_ovf;
    end
  end
endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb_booth_product_accumulator: random and directed frames on 16- and 8-bit accumulators against an arithmetic model
module tb_booth_product_accumulator;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [7:0] in_prod = 0;
  logic ir16, ov16, of16, ir8, ov8, of8;
  logic [15:0] acc16;
  logic [7:0] acc8;
  logic [3:0] cnt16, cnt8;
  int n_tests = 0, n_fail = 0;
  longint m16, m8;
  int mcnt;
  bit mo16, mo8, gaps;
  byte q[$];
  always #5 clk = ~clk;
  booth_product_accumulator #(.ACC_W(16), .CNT_W(4)) d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16), .in_prod(in_prod),
    .in_last(in_last), .out_valid(ov16), .out_ready(out_ready), .out_acc(acc16),
    .out_count(cnt16), .out_ovf(of16));
  booth_product_accumulator #(.ACC_W(8), .CNT_W(4)) d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8), .in_prod(in_prod),
    .in_last(in_last), .out_valid(ov8), .out_ready(out_ready), .out_acc(acc8),
    .out_count(cnt8), .out_ovf(of8));
  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic bit oflow(input longint a, input longint p, input int w);
    longint one = 1;
    return (a + p > (one <<< (w - 1)) - 1) || (a + p < -(one <<< (w - 1)));
  endfunction
  function automatic longint nxt(input longint a, input longint p, input int w);
    longint one = 1;
    longint hi = (one <<< (w - 1)) - 1;
    longint t = a + p;
    if (!oflow(a, p, w)) return t;
`ifdef BOOTH_ACC_SAT_EN
    return t > hi ? hi : -hi - 1;
`else
    return t > hi ? t - (one <<< w) : t + (one <<< w);
`endif
  endfunction
  task automatic clear_model();
    m16 = 0; m8 = 0; mcnt = 0; mo16 = 0; mo8 = 0;
  endtask
  task automatic do_reset();
    rst_n = 0; in_valid = 0; in_last = 0; out_ready = 0;
    @(posedge clk); #1;
    rst_n = 1;
    clear_model();
  endtask
  task automatic check_outs(input string tag);
    chk({tag, "_acc16"}, longint'($signed(acc16)), m16);
    chk({tag, "_cnt16"}, cnt16, mcnt);
    chk({tag, "_ovf16"}, of16, mo16);
    chk({tag, "_acc8"}, longint'($signed(acc8)), m8);
    chk({tag, "_cnt8"}, cnt8, mcnt);
    chk({tag, "_ovf8"}, of8, mo8);
  endtask
  task automatic send(input byte p, input bit last);
    int g = gaps ? $urandom_range(0, 2) : 0;
    repeat (g) begin
      in_valid = 0; in_prod = 8'($urandom); in_last = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1; in_prod = p; in_last = last;
    for (int k = 0; k < 50 && !ir16; k++) begin @(posedge clk); #1; end
    if (!ir16) chk("ready_timeout", ir16, 1);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    mo16 |= oflow(m16, p, 16); m16 = nxt(m16, p, 16);
    mo8 |= oflow(m8, p, 8); m8 = nxt(m8, p, 8);
    mcnt = mcnt < 15 ? mcnt + 1 : 15;
  endtask
  task automatic finish_frame(input int hold);
    chk("valid16", ov16, 1);
    chk("valid8", ov8, 1);
    chk("ready_done", ir16, 0);
    check_outs("res");
    repeat (hold) begin
      in_valid = 1; in_prod = 8'($urandom); in_last = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", ov16, 1);
      chk("hold_ready", ir16, 0);
      check_outs("hold");
    end
    in_valid = 1; in_prod = 8'($urandom); out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0; in_valid = 0; in_last = 0;
    clear_model();
    chk("rel_valid", ov16, 0);
    chk("rel_ready", ir16, 1);
    chk("rel_ready8", ir8, 1);
    check_outs("rel");
  endtask
  task automatic run_frame(input int hold);
    foreach (q[i]) send(q[i], i == q.size() - 1);
    finish_frame(hold);
  endtask
  initial begin
    do_reset();
    chk("rst_valid", ov16, 0);
    chk("rst_ready", ir16, 1);
    check_outs("rst");
    gaps = 0;
    q = '{3, -5, 64}; run_frame(0);
    chk("plan_acc", m16, 0);
    q = '{-56}; run_frame(0);
    q = '{5, -9}; run_frame(5);
    q = '{64, 64}; run_frame(1);
    q = '{10, 20};
    foreach (q[i]) send(q[i], 0);
    do_reset();
    check_outs("midrst");
    q = '{7}; run_frame(0);
    gaps = 1;
    q = {}; repeat (20) q.push_back(1); run_frame(2);
    gaps = 0;
    q = {}; repeat (300) q.push_back(127); run_frame(0);
    q = {}; repeat (300) q.push_back(-128); run_frame(0);
    for (int f = 0; f < 30; f++) begin
      gaps = 1'($urandom);
      q = {};
      repeat ($urandom_range(1, 20)) q.push_back(byte'($urandom));
      run_frame($urandom_range(0, 3));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
